audio_sample_buffer: RTL and testbench
======================================

Name: audio_sample_buffer

Overview:
- Mono record/playback sample store that sits directly on the codec serialiser's parallel side.
- Captures left-channel `audio_input` words on the codec's `sample_end[1]` strobe into on-chip RAM.
- Replays them onto `audio_output` on the codec's `sample_req[1]` strobe.
- Drives the codec's `channel_sel`, and is controlled by one-cycle command pulses from the user-interface logic.

Parameters:
- ADDR_W, 15, RAM address width; capacity DEPTH = 2**ADDR_W 16-bit samples.
- DATA_W, 16, sample width; must match the codec word.

Ports:
- clk  in  1  system clock, same domain as the codec.
- reset  in  1  synchronous, active-high.
- cmd_record  in  1  one-cycle pulse: start a new recording.
- cmd_play  in  1  one-cycle pulse: start playback from address 0.
- cmd_stop  in  1  one-cycle pulse: abort the current operation.
- loop_en  in  1  level; when 1, playback wraps to 0 at end instead of stopping.
- sample_end  in  2  codec strobe; [1]=left input word valid, [0]=right.
- sample_req  in  2  codec strobe; [1]=left output word needed next cycle, [0]=right.
- audio_input  in  DATA_W  codec captured word.
- audio_output  out  DATA_W  word to codec serialiser.
- channel_sel  out  2  codec channel enable; [1]=left, [0]=right.
- state  out  2  0=IDLE, 1=RECORD, 2=PLAY.
- rec_length  out  ADDR_W+1  number of valid samples stored (0..DEPTH).
- position  out  ADDR_W  current read/write address.
- done  out  1  one-cycle pulse when RECORD fills or PLAY ends without loop.

Behaviour:
- Reset values:
  - state=IDLE, audio_output=0, channel_sel=2'b11, rec_length=0, position=0, done=0.
  - Internal wr/rd addresses are 0.
  - RAM contents are not cleared.
- Command priority in a cycle: cmd_stop > cmd_record > cmd_play. Commands are accepted in any state.
- cmd_stop:
  - state<=IDLE, audio_output<=0.
  - rec_length keeps its value, except in RECORD where it freezes at the current write count.
- cmd_record:
  - state<=RECORD, position<=0, rec_length<=0.
  - Any playback is abandoned.
- cmd_play:
  - If rec_length==0: ignored, state unchanged.
  - Otherwise: state<=PLAY, position<=0.
- channel_sel:
  - IDLE: 2'b11, so the codec loads audio_output=0 on both channels (silence).
  - RECORD and PLAY: 2'b10. Left only is captured; the codec repeats the left output word on the right.
- RECORD:
  - On sample_end[1]: RAM[position]<=audio_input, position<=position+1, rec_length<=rec_length+1.
  - sample_end[0] is ignored.
  - When the write takes rec_length to DEPTH: state<=IDLE, done=1 for one cycle, position wraps to 0, no further writes.
- PLAY uses a synchronous RAM read with 1-cycle latency on a registered rd_data.
  - rd_data always reflects RAM[position] from the previous cycle.
  - On sample_req[1]: audio_output<=rd_data and position<=position+1, both on the same edge.
  - audio_output is valid exactly one cycle after the sample_req[1] pulse, which is the codec's load cycle.
  - The next prefetch completes well before the next request (minimum spacing 256 clks).
  - sample_req[0] is ignored; audio_output holds.
- End of playback: when position+1 == rec_length on a sample_req[1], the word is still output.
  - loop_en=1: position<=0 and PLAY continues.
  - loop_en=0: state<=IDLE, done=1, and audio_output holds the last sample until the next transition to IDLE-silence on the following sample_req[1].
- Leaving PLAY or RECORD to IDLE: audio_output is forced to 0 on the first sample_req[1] seen in IDLE, never mid-word.
- cmd_stop is the exception: it zeroes audio_output immediately.
- Simultaneous events:
  - A command in the same cycle as a strobe: the command wins and the strobe is dropped.
  - sample_end[1] in the same cycle as the fill condition: the write happens, then IDLE.
- Width rules:
  - rec_length is ADDR_W+1 bits, so it can represent DEPTH.
  - position wraps modulo DEPTH.
  - No arithmetic on sample data; words pass through unchanged.
- Reset asserted mid-operation: immediate return to reset values. Partial recording length is lost.

Test Plan:
- Reset, then idle for 1000 clks.
  - Required: channel_sel=11, audio_output=0, state=0, rec_length=0, done=0.
- Record with ADDR_W=4: cmd_record, then 16 sample_end[1] strobes with audio_input=16'h0100+i.
  - Required: rec_length=16, done pulses once on the 16th write, state=IDLE.
  - A 17th strobe writes nothing.
- Play after that recording with loop_en=0: cmd_play, then sample_req[1] every 256 clks.
  - Required: audio_output equals 16'h0100..16'h010F, each valid 1 clk after its strobe.
  - done fires on the 16th request; the next request drives audio_output=0.
- Loop playback with loop_en=1.
  - Required: after 16'h010F the next output is 16'h0100; state stays PLAY; done is never asserted.
- Abort and re-record: cmd_stop after 5 recorded samples.
  - Required: rec_length=5, state=IDLE, audio_output=0.
  - cmd_play with rec_length=0 after a cmd_record+cmd_stop with no strobes is ignored.
- Priority: cmd_stop and cmd_play in the same cycle during RECORD.
  - Required: state=IDLE.
  - A sample_end[1] coincident with cmd_record is not written; position=0.

Source files
------------

// File: rtl/audio_sample_buffer.sv
// Mono record/playback sample store on the codec's parallel side.
// Left-channel words are captured on sample_end[1] into an inferred RAM
// and replayed onto audio_output on sample_req[1]. One-cycle command
// pulses (stop > record > play) steer a three-state controller.
module audio_sample_buffer #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_record,
  input  logic              cmd_play,
  input  logic              cmd_stop,
  input  logic              loop_en,
  input  logic [1:0]        sample_end,
  input  logic [1:0]        sample_req,
  input  logic [DATA_W-1:0] audio_input,
  output logic [DATA_W-1:0] audio_output,
  output logic [1:0]        channel_sel,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   rec_length,
  output logic [ADDR_W-1:0] position,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECORD = 2'd1;
  localparam logic [1:0] ST_PLAY   = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  logic [1:0]        state_reg;
  logic [DATA_W-1:0] audio_output_reg;
  logic [ADDR_W:0]   rec_length_reg;
  logic [ADDR_W-1:0] position_reg;
  logic              done_reg;

  // A play request with nothing recorded is ignored and must not swallow
  // a coincident strobe, so only accepted commands pre-empt strobes.
  logic              play_ok;
  logic              any_cmd;
  logic              write_en;
  logic [ADDR_W-1:0] position_inc;
  logic [ADDR_W:0]   position_ext_inc;
  logic [ADDR_W:0]   rec_length_inc;

  assign play_ok          = cmd_play && (rec_length_reg != '0);
  assign any_cmd          = cmd_stop || cmd_record || play_ok;
  assign write_en         = (state_reg == ST_RECORD) && sample_end[1] && !any_cmd;
  assign position_inc     = position_reg + ADDR_W'(1);
  assign position_ext_inc = {1'b0, position_reg} + (ADDR_W + 1)'(1);
  assign rec_length_inc   = rec_length_reg + (ADDR_W + 1)'(1);

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[position_reg] <= audio_input;
    end
  end

  // Registered read: rd_data_reg holds RAM[position] from the previous cycle,
  // long settled by the time the next sample_req[1] arrives.
  always_ff @(posedge clk) begin
    rd_data_reg <= mem[position_reg];
  end

  // Controller: command handling first, then strobes for the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      audio_output_reg <= '0;
      rec_length_reg   <= '0;
      position_reg     <= '0;
      done_reg         <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (cmd_stop) begin
        // Zero output immediately; rec_length already tracks the write count.
        state_reg        <= ST_IDLE;
        audio_output_reg <= '0;
      end else if (cmd_record) begin
        state_reg      <= ST_RECORD;
        position_reg   <= '0;
        rec_length_reg <= '0;
      end else if (play_ok) begin
        state_reg    <= ST_PLAY;
        position_reg <= '0;
      end else begin
        case (state_reg)
          ST_RECORD: begin
            if (sample_end[1]) begin
              position_reg   <= position_inc;
              rec_length_reg <= rec_length_inc;
              if (rec_length_inc == FULL_COUNT) begin
                state_reg <= ST_IDLE;
                done_reg  <= 1'b1;
              end
            end
          end
          ST_PLAY: begin
            if (sample_req[1]) begin
              audio_output_reg <= rd_data_reg;
              if (position_ext_inc == rec_length_reg) begin
                position_reg <= '0;
                if (!loop_en) begin
                  state_reg <= ST_IDLE;
                  done_reg  <= 1'b1;
                end
              end else begin
                position_reg <= position_inc;
              end
            end
          end
          default: begin
            // Silence is applied on a word boundary, never mid-word.
            if (sample_req[1]) begin
              audio_output_reg <= '0;
            end
          end
        endcase
      end
    end
  end

  assign channel_sel  = (state_reg == ST_IDLE) ? 2'b11 : 2'b10;
  assign audio_output = audio_output_reg;
  assign state        = state_reg;
  assign rec_length   = rec_length_reg;
  assign position     = position_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// Directed bench for audio_sample_buffer with a 16-entry RAM.
module tb_audio_sample_buffer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  logic              clk;
  logic              reset;
  logic              cmd_record;
  logic              cmd_play;
  logic              cmd_stop;
  logic              loop_en;
  logic [1:0]        sample_end;
  logic [1:0]        sample_req;
  logic [DATA_W-1:0] audio_input;
  logic [DATA_W-1:0] audio_output;
  logic [1:0]        channel_sel;
  logic [1:0]        state;
  logic [ADDR_W:0]   rec_length;
  logic [ADDR_W-1:0] position;
  logic              done;

  int n_cmp;
  int n_bad;

  audio_sample_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_record(cmd_record), .cmd_play(cmd_play), .cmd_stop(cmd_stop),
    .loop_en(loop_en), .sample_end(sample_end), .sample_req(sample_req),
    .audio_input(audio_input), .audio_output(audio_output),
    .channel_sel(channel_sel), .state(state), .rec_length(rec_length),
    .position(position), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on negedge so the following posedge sees the pulse; return on the
  // next negedge, after that posedge has taken effect.
  task automatic pulse_cmd(input logic s, input logic r, input logic p);
    @(negedge clk);
    cmd_stop = s; cmd_record = r; cmd_play = p;
    @(negedge clk);
    cmd_stop = 1'b0; cmd_record = 1'b0; cmd_play = 1'b0;
  endtask

  task automatic strobe_in(input logic [DATA_W-1:0] d);
    @(negedge clk);
    sample_end = 2'b10; audio_input = d;
    @(negedge clk);
    sample_end = 2'b00;
  endtask

  task automatic test_reset;
    int done_seen;
    done_seen = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL reset_done: got %0d pulses want 0", done_seen); end
    n_cmp++; if (channel_sel !== 2'b11) begin n_bad++; $display("FAIL reset_chsel: got %b want 11", channel_sel); end
    n_cmp++; if (audio_output !== 16'h0000) begin n_bad++; $display("FAIL reset_out: got %h want 0000", audio_output); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (rec_length !== 5'd0) begin n_bad++; $display("FAIL reset_len: got %0d want 0", rec_length); end
    n_cmp++; if (position !== 4'd0) begin n_bad++; $display("FAIL reset_pos: got %0d want 0", position); end
    $display("test_reset: 1000 idle clks done");
  endtask

  task automatic test_record;
    pulse_cmd(1'b0, 1'b1, 1'b0);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL rec_state: got %0d want 1", state); end
    n_cmp++; if (channel_sel !== 2'b10) begin n_bad++; $display("FAIL rec_chsel: got %b want 10", channel_sel); end
    for (int i = 0; i < 16; i++) begin
      strobe_in(16'h0100 + 16'(i));
      n_cmp++; if (done !== (i == 15)) begin n_bad++; $display("FAIL rec_done[%0d]: got %b want %b", i, done, (i == 15)); end
      $display("record write %0d data %h len %0d", i, 16'h0100 + 16'(i), rec_length);
    end
    n_cmp++; if (rec_length !== 5'd16) begin n_bad++; $display("FAIL rec_len: got %0d want 16", rec_length); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rec_fill_state: got %0d want 0", state); end
    n_cmp++; if (position !== 4'd0) begin n_bad++; $display("FAIL rec_fill_pos: got %0d want 0", position); end
    strobe_in(16'hDEAD);
    n_cmp++; if (rec_length !== 5'd16) begin n_bad++; $display("FAIL rec_17th_len: got %0d want 16", rec_length); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rec_17th_done: got %b want 0", done); end
  endtask

  task automatic test_play;
    logic [DATA_W-1:0] prev;
    loop_en = 1'b0;
    prev = audio_output;
    pulse_cmd(1'b0, 1'b0, 1'b1);
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL play_state: got %0d want 2", state); end
    for (int i = 0; i < 17; i++) begin
      repeat (255) @(negedge clk);
      sample_req = 2'b10;
      n_cmp++; if (audio_output !== prev) begin n_bad++; $display("FAIL play_hold[%0d]: got %h want %h", i, audio_output, prev); end
      @(negedge clk);
      sample_req = 2'b00;
      prev = (i < 16) ? 16'h0100 + 16'(i) : 16'h0000;
      n_cmp++; if (audio_output !== prev) begin n_bad++; $display("FAIL play_out[%0d]: got %h want %h", i, audio_output, prev); end
      n_cmp++; if (done !== (i == 15)) begin n_bad++; $display("FAIL play_done[%0d]: got %b want %b", i, done, (i == 15)); end
      $display("play request %0d out %h", i, audio_output);
    end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL play_end_state: got %0d want 0", state); end
  endtask

  task automatic test_loop;
    int done_seen;
    logic [DATA_W-1:0] exp;
    done_seen = 0;
    loop_en = 1'b1;
    pulse_cmd(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      repeat (255) begin
        @(negedge clk);
        if (done !== 1'b0) done_seen++;
      end
      sample_req = 2'b10;
      @(negedge clk);
      sample_req = 2'b00;
      if (done !== 1'b0) done_seen++;
      exp = 16'h0100 + 16'(i % 16);
      n_cmp++; if (audio_output !== exp) begin n_bad++; $display("FAIL loop_out[%0d]: got %h want %h", i, audio_output, exp); end
      $display("loop request %0d out %h", i, audio_output);
    end
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL loop_state: got %0d want 2", state); end
    n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL loop_done: got %0d pulses want 0", done_seen); end
    pulse_cmd(1'b1, 1'b0, 1'b0);
    n_cmp++; if (audio_output !== 16'h0000) begin n_bad++; $display("FAIL stop_out: got %h want 0000", audio_output); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL stop_state: got %0d want 0", state); end
    loop_en = 1'b0;
  endtask

  task automatic test_abort;
    pulse_cmd(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) strobe_in(16'h0200 + 16'(i));
    n_cmp++; if (position !== 4'd5) begin n_bad++; $display("FAIL abort_pos: got %0d want 5", position); end
    pulse_cmd(1'b1, 1'b0, 1'b0);
    n_cmp++; if (rec_length !== 5'd5) begin n_bad++; $display("FAIL abort_len: got %0d want 5", rec_length); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL abort_state: got %0d want 0", state); end
    n_cmp++; if (audio_output !== 16'h0000) begin n_bad++; $display("FAIL abort_out: got %h want 0000", audio_output); end
    pulse_cmd(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      repeat (255) @(negedge clk);
      sample_req = 2'b10;
      @(negedge clk);
      sample_req = 2'b00;
      n_cmp++; if (audio_output !== 16'h0200 + 16'(i)) begin n_bad++; $display("FAIL abort_play[%0d]: got %h want %h", i, audio_output, 16'h0200 + 16'(i)); end
    end
    pulse_cmd(1'b0, 1'b1, 1'b0);
    pulse_cmd(1'b1, 1'b0, 1'b0);
    pulse_cmd(1'b0, 1'b0, 1'b1);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL empty_play_state: got %0d want 0", state); end
    n_cmp++; if (rec_length !== 5'd0) begin n_bad++; $display("FAIL empty_play_len: got %0d want 0", rec_length); end
    $display("abort/re-record sequence complete");
  endtask

  task automatic test_priority;
    pulse_cmd(1'b0, 1'b1, 1'b0);
    strobe_in(16'h0A0A);
    strobe_in(16'h0B0B);
    pulse_cmd(1'b1, 1'b0, 1'b1);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL prio_stop_play: got %0d want 0", state); end
    n_cmp++; if (rec_length !== 5'd2) begin n_bad++; $display("FAIL prio_len: got %0d want 2", rec_length); end
    @(negedge clk);
    cmd_record = 1'b1; sample_end = 2'b10; audio_input = 16'hBEEF;
    @(negedge clk);
    cmd_record = 1'b0; sample_end = 2'b00;
    n_cmp++; if (position !== 4'd0) begin n_bad++; $display("FAIL prio_rec_pos: got %0d want 0", position); end
    n_cmp++; if (rec_length !== 5'd0) begin n_bad++; $display("FAIL prio_rec_len: got %0d want 0", rec_length); end
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL prio_rec_state: got %0d want 1", state); end
    $display("priority checks complete");
  endtask

  task automatic test_reset_mid;
    pulse_cmd(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) strobe_in(16'h0300 + 16'(i));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (rec_length !== 5'd0) begin n_bad++; $display("FAIL mid_reset_len: got %0d want 0", rec_length); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL mid_reset_state: got %0d want 0", state); end
    n_cmp++; if (position !== 4'd0) begin n_bad++; $display("FAIL mid_reset_pos: got %0d want 0", position); end
    n_cmp++; if (channel_sel !== 2'b11) begin n_bad++; $display("FAIL mid_reset_chsel: got %b want 11", channel_sel); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; cmd_record = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0;
    loop_en = 1'b0; sample_end = 2'b00; sample_req = 2'b00; audio_input = '0;
    test_reset;
    test_record;
    test_play;
    test_loop;
    test_abort;
    test_priority;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
